// File: rtl/class_merge_if.sv
// Merge-arbiter bus: two class FIFO read ports, downstream back-pressure,
// merged output word and delivery counters.
interface class_merge_if #(
  parameter int DATA_SIZE = 10
);
  logic [DATA_SIZE-1:0] fifo0_data;
  logic                 fifo0_empty;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 fifo1_empty;
  logic                 down_af;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] out;
  logic                 valid_out;
  logic [7:0]           cnt0;
  logic [7:0]           cnt1;
  logic                 idle;

  modport master (
    input  fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, down_af,
    output pop0, pop1, out, valid_out, cnt0, cnt1, idle
  );

  modport slave (
    output fifo0_data, fifo0_empty, fifo1_data, fifo1_empty, down_af,
    input  pop0, pop1, out, valid_out, cnt0, cnt1, idle
  );
endinterface

// File: rtl/class_merge.sv
// Two-class FIFO merge: class 0 is preferred, class 1 is granted after
// STARVE_MAX consecutive class-0 grants; read data emerges two cycles after a pop.
module class_merge #(
  parameter int DATA_SIZE  = 10,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  class_merge_if.master bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 pop0_q, pop1_q;
  logic                 vld_p0_q, tag_p0_q;
  logic                 vld_p1_q;
  logic [DATA_SIZE-1:0] out_p1_q;
  logic [7:0]           cnt0_q, cnt1_q;

  // The grant decision sees the starvation count including the current cycle's grant.
  always_comb begin
    starve_d = starve_q;
    if (state_q == GRANT1 || bus.fifo1_empty) begin
      starve_d = '0;
    end else if (state_q == GRANT0 && starve_q != SMAX) begin
      starve_d = starve_q + 1'b1;
    end

    state_d = IDLE;
    if (bus.down_af || (bus.fifo0_empty && bus.fifo1_empty)) begin
      state_d = IDLE;
    end else if (!bus.fifo0_empty && (bus.fifo1_empty || starve_d < SMAX)) begin
      state_d = GRANT0;
    end else begin
      state_d = GRANT1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      pop0_q   <= 1'b0;
      pop1_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      tag_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      out_p1_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      pop0_q   <= (state_d == GRANT0);
      pop1_q   <= (state_d == GRANT1);
      // p0: FIFO read data is on the bus; tag remembers which FIFO it came from
      vld_p0_q <= (state_q != IDLE);
      tag_p0_q <= (state_q == GRANT1);
      // p1: registered merged word and delivery counters
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) begin
        out_p1_q <= tag_p0_q ? bus.fifo1_data : bus.fifo0_data;
        if (tag_p0_q) begin
          cnt1_q <= cnt1_q + 8'd1;
        end else begin
          cnt0_q <= cnt0_q + 8'd1;
        end
      end
    end
  end

  assign bus.pop0      = pop0_q;
  assign bus.pop1      = pop1_q;
  assign bus.out       = out_p1_q;
  assign bus.valid_out = vld_p1_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
  assign bus.idle      = (state_q == IDLE) && !vld_p0_q && !vld_p1_q;
endmodule

// File: tb/tb_class_merge.sv
// Directed bench for class_merge: two model FIFOs with empty flags that
// account for a pop issued in the current cycle, plus pop/output logs.
module tb_class_merge;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  class_merge_if #(.DATA_SIZE(DW)) bus ();
  class_merge #(.DATA_SIZE(DW), .STARVE_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem0 [512];
  logic [DW-1:0] mem1 [512];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int ovr0 = 0, ovr1 = 0, cyc = 0, both = 0;

  assign bus.fifo0_empty = (wr0 - rd0 - (bus.pop0 ? 1 : 0)) <= 0;
  assign bus.fifo1_empty = (wr1 - rd1 - (bus.pop1 ? 1 : 0)) <= 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.pop0) begin
      if (rd0 == wr0) ovr0 <= ovr0 + 1;
      bus.fifo0_data <= mem0[rd0 % 512];
      rd0 <= rd0 + 1;
    end
    if (bus.pop1) begin
      if (rd1 == wr1) ovr1 <= ovr1 + 1;
      bus.fifo1_data <= mem1[rd1 % 512];
      rd1 <= rd1 + 1;
    end
  end

  bit            pcls [$];
  int            pcyc [$];
  logic [DW-1:0] gdat [$];
  int            gcyc [$];

  always @(negedge clk) begin
    if (bus.pop0 && bus.pop1) both <= both + 1;
    if (bus.pop0) begin pcls.push_back(1'b0); pcyc.push_back(cyc); end
    if (bus.pop1) begin pcls.push_back(1'b1); pcyc.push_back(cyc); end
    if (bus.valid_out) begin gdat.push_back(bus.out); gcyc.push_back(cyc); end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push0(input logic [DW-1:0] v);
    mem0[wr0 % 512] = v;
    wr0++;
  endtask

  task automatic push1(input logic [DW-1:0] v);
    mem1[wr1 % 512] = v;
    wr1++;
  endtask

  task automatic clear_log();
    pcls.delete(); pcyc.delete(); gdat.delete(); gcyc.delete();
  endtask

  function automatic logic [31:0] gd(input int i);
    return (i < gdat.size()) ? 32'(gdat[i]) : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] gc(input int i);
    return (i < gcyc.size()) ? 32'(gcyc[i]) : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] pc(input int i);
    return (i < pcyc.size()) ? 32'(pcyc[i]) : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] pat();
    logic [31:0] v = '0;
    foreach (pcls[i]) v = {v[30:0], pcls[i]};
    return v;
  endfunction

  initial begin
    int t_rel, raise_c, drop_c, n, first_after;
    logic [19:0] ep;
    int i0, i1;
    logic [31:0] expw;

    bus.down_af = 1'b0;
    tick(3);
    chk("rst_pop0", bus.pop0, 0);
    chk("rst_pop1", bus.pop1, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_cnt0", bus.cnt0, 0);
    chk("rst_cnt1", bus.cnt1, 0);
    chk("rst_idle", bus.idle, 1);

    // two class-0 words, fifo1 empty
    push0(10'h011); push0(10'h012);
    tick(1);
    chk("rst_hold_nopop", pcls.size(), 0);
    clear_log();
    reset = 1'b0;
    t_rel = cyc;
    tick(8);
    chk("t1_npop", pcls.size(), 2);
    chk("t1_cls", pat(), 0);
    chk("t1_first_pop_after_rst", (pc(0) - t_rel) >= 1 && pcyc.size() > 0, 1);
    chk("t1_latency", gc(0) - pc(0), 2);
    chk("t1_nout", gdat.size(), 2);
    chk("t1_out0", gd(0), 10'h011);
    chk("t1_out1", gd(1), 10'h012);
    chk("t1_cnt0", bus.cnt0, 2);
    chk("t1_cnt1", bus.cnt1, 0);
    chk("t1_idle", bus.idle, 1);

    // both classes loaded with 10 words: starvation pattern
    bus.down_af = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push0(10'h100 + 10'(i));
      push1(10'h200 + 10'(i));
    end
    clear_log();
    tick(1);
    chk("t2_af_nopop", pcls.size(), 0);
    bus.down_af = 1'b0;
    tick(30);
    ep = 20'h084FF;
    chk("t2_npop", pcls.size(), 20);
    chk("t2_grant_order", pat(), 32'(ep));
    chk("t2_nout", gdat.size(), 20);
    i0 = 0; i1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (ep[19-k]) begin expw = 32'h200 + 32'(i1); i1++; end
      else begin expw = 32'h100 + 32'(i0); i0++; end
      chk($sformatf("t2_out%0d", k), gd(k), expw);
    end
    chk("t2_both", both, 0);
    chk("t2_cnt0", bus.cnt0, 12);
    chk("t2_cnt1", bus.cnt1, 10);
    chk("t2_idle", bus.idle, 1);

    // back-pressure mid-stream
    clear_log();
    for (int i = 0; i < 8; i++) push0(10'h140 + 10'(i));
    n = 0;
    while (pcls.size() < 3 && n < 20) begin tick(1); n++; end
    chk("t3_start_timeout", pcls.size() >= 3, 1);
    raise_c = cyc;
    bus.down_af = 1'b1;
    tick(5);
    n = 0;
    foreach (pcyc[i]) if (pcyc[i] > raise_c) n++;
    chk("t3_pops_after_af", n, 0);
    n = 0;
    foreach (gcyc[i]) if (gcyc[i] > raise_c) n++;
    chk("t3_inflight_out", n, 2);
    chk("t3_idle_af", bus.idle, 1);
    drop_c = cyc;
    bus.down_af = 1'b0;
    tick(15);
    first_after = -1;
    foreach (pcyc[i]) if (pcyc[i] > drop_c && first_after < 0) first_after = pcyc[i];
    chk("t3_resume", first_after - drop_c, 1);
    chk("t3_nout", gdat.size(), 8);
    chk("t3_last", gd(7), 10'h147);
    chk("t3_cnt0", bus.cnt0, 20);

    // single class-1 word
    clear_log();
    push1(10'h2AA);
    tick(8);
    chk("t4_npop", pcls.size(), 1);
    chk("t4_cls", pat(), 1);
    chk("t4_out", gd(0), 10'h2AA);
    chk("t4_latency", gc(0) - pc(0), 2);
    chk("t4_hold_out", bus.out, 10'h2AA);
    chk("t4_valid_low", bus.valid_out, 0);
    chk("t4_cnt1", bus.cnt1, 11);
    chk("t4_cnt0", bus.cnt0, 20);

    // reset while a word is in flight
    clear_log();
    push0(10'h033);
    n = 0;
    while (pcls.size() < 1 && n < 10) begin tick(1); n++; end
    chk("t5_pop_timeout", pcls.size(), 1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    chk("t5_no_valid", gdat.size(), 0);
    chk("t5_npop", pcls.size(), 1);
    chk("t5_out", bus.out, 0);
    chk("t5_cnt0", bus.cnt0, 0);
    chk("t5_cnt1", bus.cnt1, 0);
    chk("t5_idle", bus.idle, 1);

    // 256 class-0 words: counter wrap
    clear_log();
    for (int i = 0; i < 256; i++) push0(10'(i));
    n = 0;
    while (gdat.size() < 256 && n < 400) begin tick(1); n++; end
    tick(3);
    chk("t6_nout", gdat.size(), 256);
    chk("t6_out100", gd(100), 100);
    chk("t6_out255", gd(255), 255);
    chk("t6_cnt0_wrap", bus.cnt0, 0);
    chk("t6_cnt1", bus.cnt1, 0);
    chk("t6_idle", bus.idle, 1);
    chk("overread0", ovr0, 0);
    chk("overread1", ovr1, 0);
    chk("both_pops", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
